// File: rtl/barrel_sched_pkg.sv
// barrel_sched_pkg
// Shared definitions for the barrel select scheduler slice: FSM state
// encoding, select bus width, the physical mux input count and the first
// illegal select code, plus a helper that flags out-of-range select values.
// Optional feature macro used by the top: BARREL_SCHED_BURST_EN.

package barrel_sched_pkg;

   // Scheduler FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEL  = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Width of the mux select bus and number of physical mux inputs
   localparam int SEL_W      = 4;
   localparam int MUX_INPUTS = 10;

   // Select codes at or above this value have no mux input behind them
   localparam logic [SEL_W-1:0] ILLEGAL_SEL_MIN = SEL_W'(MUX_INPUTS);

   // Width of the burst counter; MAX_BURST is at most 16 so the count tops at 15
   localparam int BURST_CNT_W = 4;

   // True when a select code addresses a real mux input
   function automatic logic selLegal(input logic [SEL_W-1:0] s);
      return (s < ILLEGAL_SEL_MIN);
   endfunction

endpackage

// File: rtl/barrel_select_scheduler_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. Searches the request vector starting
// one above the last winner and wraps around, so the last winner has the
// lowest priority.
// Ports:
//   i_req    - request vector, one bit per requester
//   i_last   - index of the previous winner (always < N)
//   o_oneHot - one-hot winner
//   o_idx    - binary index of the winner
//   o_any    - at least one request is pending

module rr_arbiter
   import barrel_sched_pkg::*;
#(
   parameter int N = 10
) (
   input  logic [N-1:0]     i_req,
   input  logic [SEL_W-1:0] i_last,
   output logic [N-1:0]     o_oneHot,
   output logic [SEL_W-1:0] o_idx,
   output logic             o_any
);

   logic w_found;

   // Two passes over constant indices: first the requesters above the last
   // winner, then the wrapped-around ones from 0 up to and including it.
   always_comb begin
      o_oneHot = '0;
      o_idx    = '0;
      w_found  = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!w_found && i_req[i] && (SEL_W'(i) > i_last)) begin
            o_oneHot[i] = 1'b1;
            o_idx       = SEL_W'(i);
            w_found     = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!w_found && i_req[i]) begin
            o_oneHot[i] = 1'b1;
            o_idx       = SEL_W'(i);
            w_found     = 1'b1;
         end
      end
      o_any = w_found;
   end

endmodule

// File: rtl/barrel_select_scheduler.sv
// barrel_select_scheduler
// Round-robin scheduler sharing one 10-input barrel select mux among up to
// ten requesters. Picks a winner, steers the mux, captures the mux output
// and presents it downstream with a valid/ready handshake.
// Optional feature: define BARREL_SCHED_BURST_EN to let a requester that
// still requests at handshake keep the mux for up to MAX_BURST words.
// Ports:
//   clk, rst_n - clock (rising edge) and asynchronous active-low reset
//   req        - level requests, held until the matching gnt pulse
//   gnt        - one-hot, one-cycle pulse when a requester's word is captured
//   select     - mux select, always 0..N_REQ-1
//   mux_data   - mux data_out
//   out_data   - captured word, out_valid qualifies it
//   out_ready  - downstream accept
//   busy       - FSM is not idle

module barrel_select_scheduler
   import barrel_sched_pkg::*;
#(
   parameter int N_REQ = 10,
   parameter int DW    = 64
`ifdef BARREL_SCHED_BURST_EN
   ,
   parameter int MAX_BURST = 4
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [SEL_W-1:0] select,
   input  logic [DW-1:0]    mux_data,
   output logic [DW-1:0]    out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   state_t               r_state;
   state_t               w_nextState;
   logic [SEL_W-1:0]     r_select;
   logic [SEL_W-1:0]     r_last;
   logic [DW-1:0]        r_outData;
   logic                 r_outValid;
   logic [N_REQ-1:0]     r_gnt;
   logic [N_REQ-1:0]     w_arbOneHot;
   logic [SEL_W-1:0]     w_arbIdx;
   logic [SEL_W-1:0]     w_arbSel;
   logic                 w_arbAny;
   logic                 w_handshake;
   logic                 w_keepBurst;
   logic [N_REQ-1:0]     w_selOneHot;

`ifdef BARREL_SCHED_BURST_EN
   localparam logic [BURST_CNT_W-1:0] BURST_LIMIT = BURST_CNT_W'(MAX_BURST - 1);
   logic [BURST_CNT_W-1:0] r_burst;
`endif

   // Same arbiter serves the IDLE pick and the re-arbitration at handshake
   rr_arbiter #(
      .N (N_REQ)
   ) u_arb (
      .i_req    (req),
      .i_last   (r_last),
      .o_oneHot (w_arbOneHot),
      .o_idx    (w_arbIdx),
      .o_any    (w_arbAny)
   );

   // Handshake, burst continuation, legal select guard and the grant vector
   // derived from the current select.
   always_comb begin
      w_handshake = r_outValid && out_ready;
      w_arbSel    = selLegal(w_arbIdx) ? w_arbIdx : '0;
`ifdef BARREL_SCHED_BURST_EN
      w_keepBurst = w_handshake && req[r_select] && (r_burst < BURST_LIMIT);
`else
      w_keepBurst = 1'b0;
`endif
      w_selOneHot = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_selOneHot[i] = (r_select == SEL_W'(i));
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: HOLD leaves only on a handshake, straight back to SEL
   // when another word (or a burst continuation) is waiting.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: if (w_arbAny) w_nextState = SEL;
         SEL:  w_nextState = HOLD;
         HOLD: begin
            if (w_handshake) begin
               w_nextState = (w_keepBurst || w_arbAny) ? SEL : IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Datapath registers: select, capture, grant pulse, RR pointer and burst
   // count. The pointer only moves when a word is actually captured, so a
   // reset in SEL leaves requester 0 first in line again.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_select   <= '0;
         r_last     <= SEL_W'(N_REQ - 1);
         r_outData  <= '0;
         r_outValid <= 1'b0;
         r_gnt      <= '0;
`ifdef BARREL_SCHED_BURST_EN
         r_burst    <= '0;
`endif
      end else begin
         r_gnt <= '0;
         case (r_state)
            IDLE: begin
               if (w_arbAny) begin
                  r_select <= w_arbSel;
`ifdef BARREL_SCHED_BURST_EN
                  r_burst  <= '0;
`endif
               end
            end
            SEL: begin
               r_outData  <= mux_data;
               r_outValid <= 1'b1;
               r_gnt      <= w_selOneHot;
               r_last     <= r_select;
            end
            HOLD: begin
               if (w_handshake) begin
                  r_outValid <= 1'b0;
                  if (w_keepBurst) begin
`ifdef BARREL_SCHED_BURST_EN
                     r_burst <= r_burst + 1'b1;
`endif
                  end else begin
                     if (w_arbAny) begin
                        r_select <= w_arbSel;
                     end
`ifdef BARREL_SCHED_BURST_EN
                     r_burst <= '0;
`endif
                  end
               end
            end
            default: begin
               r_outValid <= 1'b0;
            end
         endcase
      end
   end

   // Output drive
   always_comb begin
      gnt       = r_gnt;
      select    = r_select;
      out_data  = r_outData;
      out_valid = r_outValid;
      busy      = (r_state != IDLE);
   end

endmodule

// File: tb/tb_barrel_select_scheduler.sv
// tb_barrel_select_scheduler
// Directed self-checking bench for barrel_select_scheduler. Models the
// external barrel mux for a 10-requester instance and a 4-requester
// instance; expected values are hand-computed constants.

module tb_barrel_select_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  req;
   logic [9:0]  gnt;
   logic [3:0]  select;
   logic [63:0] muxData;
   logic [63:0] outData;
   logic        outValid;
   logic        outReady;
   logic        busy;
   logic [63:0] d [10];

   logic [3:0]  req2;
   logic [3:0]  gnt2;
   logic [3:0]  select2;
   logic [63:0] muxData2;
   logic [63:0] outData2;
   logic        outValid2;
   logic        outReady2;
   logic        busy2;
   logic [63:0] d2 [4];

   int vectors     = 0;
   int miscompares = 0;
   int exp5 [9];

   // External mux models; an out-of-range select yields X and miscompares
   assign muxData  = (select < 4'd10) ? d[select] : 'x;
   assign muxData2 = (select2 < 4'd4) ? d2[select2[1:0]] : 'x;

   always #5 clk = ~clk;

   barrel_select_scheduler dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .gnt       (gnt),
      .select    (select),
      .mux_data  (muxData),
      .out_data  (outData),
      .out_valid (outValid),
      .out_ready (outReady),
      .busy      (busy)
   );

   barrel_select_scheduler #(.N_REQ(4)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req2),
      .gnt       (gnt2),
      .select    (select2),
      .mux_data  (muxData2),
      .out_data  (outData2),
      .out_valid (outValid2),
      .out_ready (outReady2),
      .busy      (busy2)
   );

   // Compare one observed value against its expected value
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic applyReset();
      req   = '0;
      req2  = '0;
      rst_n = 1'b0;
      applyStimulus();
      applyStimulus();
      rst_n = 1'b1;
   endtask

   function automatic logic [9:0] oneHot10(input int w);
      logic [9:0] v;
      v = 10'd1;
      return v << w;
   endfunction

   initial begin
      for (int i = 0; i < 10; i++) d[i] = 64'h1111_0000_0000_0000 + 64'(i) * 64'h0101;
      d[0] = 64'hA5A5_0000_0000_0001;
      for (int i = 0; i < 4; i++) d2[i] = 64'hBEEF_0000_0000_0000 + 64'(i);
`ifdef BARREL_SCHED_BURST_EN
      exp5 = '{3, 3, 3, 3, 5, 5, 5, 5, 3};
`else
      exp5 = '{3, 5, 3, 5, 3, 5, 3, 5, 3};
`endif
      rst_n     = 1'b0;
      req       = '0;
      req2      = '0;
      outReady  = 1'b1;
      outReady2 = 1'b1;
      #1;
      checkOutput("rst_gnt", 64'(gnt), 64'd0);
      checkOutput("rst_select", 64'(select), 64'd0);
      checkOutput("rst_out_data", outData, 64'd0);
      checkOutput("rst_out_valid", 64'(outValid), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_select2", 64'(select2), 64'd0);
      applyStimulus();
      applyStimulus();
      rst_n = 1'b1;

      $display("[TB] single word from requester 0");
      req = 10'b0000000001;
      applyStimulus();
      checkOutput("t1_select", 64'(select), 64'd0);
      checkOutput("t1_valid_lo", 64'(outValid), 64'd0);
      checkOutput("t1_busy", 64'(busy), 64'd1);
      applyStimulus();
      checkOutput("t1_valid", 64'(outValid), 64'd1);
      checkOutput("t1_data", outData, 64'hA5A5_0000_0000_0001);
      checkOutput("t1_gnt", 64'(gnt), 64'(10'b0000000001));
      req = '0;
      applyStimulus();
      checkOutput("t1_valid_drop", 64'(outValid), 64'd0);
      checkOutput("t1_gnt_drop", 64'(gnt), 64'd0);
      checkOutput("t1_idle", 64'(busy), 64'd0);

      $display("[TB] all requesters, round robin");
      applyReset();
      req = 10'b1111111111;
      applyStimulus();
      checkOutput("t2_first_sel", 64'(select), 64'd0);
      for (int n = 0; n <= 10; n++) begin
         applyStimulus();
         checkOutput("t2_valid", 64'(outValid), 64'd1);
         checkOutput("t2_gnt", 64'(gnt), 64'(oneHot10(n % 10)));
         checkOutput("t2_data", outData, d[n % 10]);
         applyStimulus();
         checkOutput("t2_gap", 64'(outValid), 64'd0);
         checkOutput("t2_next_sel", 64'(select), 64'((n + 1) % 10));
         checkOutput("t2_gnt_gap", 64'(gnt), 64'd0);
      end
      req = '0;
      applyStimulus();
      checkOutput("t2_late_drop_gnt", 64'(gnt), 64'(10'b0000000010));
      applyStimulus();
      checkOutput("t2_idle", 64'(busy), 64'd0);

      $display("[TB] stall with out_ready low");
      outReady = 1'b0;
      req      = 10'b0000010000;
      applyStimulus();
      checkOutput("t3_select", 64'(select), 64'd4);
      applyStimulus();
      checkOutput("t3_gnt", 64'(gnt), 64'(10'b0000010000));
      checkOutput("t3_data", outData, d[4]);
      req = 10'b0010000000;
      for (int n = 0; n < 5; n++) begin
         applyStimulus();
         checkOutput("t3_hold_valid", 64'(outValid), 64'd1);
         checkOutput("t3_hold_data", outData, d[4]);
         checkOutput("t3_hold_select", 64'(select), 64'd4);
         checkOutput("t3_hold_gnt", 64'(gnt), 64'd0);
      end
      outReady = 1'b1;
      applyStimulus();
      checkOutput("t3_hs_valid", 64'(outValid), 64'd0);
      checkOutput("t3_hs_select", 64'(select), 64'd7);
      applyStimulus();
      checkOutput("t3_gnt7", 64'(gnt), 64'(10'b0010000000));
      checkOutput("t3_data7", outData, d[7]);
      req = '0;
      applyStimulus();
      checkOutput("t3_idle", 64'(busy), 64'd0);

      $display("[TB] reset while in SEL");
      req = 10'b0000000100;
      applyStimulus();
      checkOutput("t4_select", 64'(select), 64'd2);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t4_async_valid", 64'(outValid), 64'd0);
      checkOutput("t4_async_gnt", 64'(gnt), 64'd0);
      checkOutput("t4_async_select", 64'(select), 64'd0);
      checkOutput("t4_async_busy", 64'(busy), 64'd0);
      applyStimulus();
      checkOutput("t4_no_gnt", 64'(gnt), 64'd0);
      rst_n = 1'b1;
      req   = 10'b0000000101;
      applyStimulus();
      checkOutput("t4_prio0_sel", 64'(select), 64'd0);
      applyStimulus();
      checkOutput("t4_prio0_gnt", 64'(gnt), 64'(10'b0000000001));
      req = 10'b0000000100;
      applyStimulus();
      checkOutput("t4_next_sel", 64'(select), 64'd2);
      applyStimulus();
      checkOutput("t4_gnt2", 64'(gnt), 64'(10'b0000000100));
      checkOutput("t4_data2", outData, d[2]);
      req = '0;
      applyStimulus();

      $display("[TB] requesters 3 and 5 held high");
      applyReset();
      req = 10'b0000101000;
      applyStimulus();
      checkOutput("t5_first_sel", 64'(select), 64'd3);
      for (int n = 0; n < 9; n++) begin
         applyStimulus();
         checkOutput("t5_gnt", 64'(gnt), 64'(oneHot10(exp5[n])));
         checkOutput("t5_data", outData, d[exp5[n]]);
         applyStimulus();
         checkOutput("t5_gap", 64'(outValid), 64'd0);
      end
      req = '0;
      applyStimulus();
      applyStimulus();
      checkOutput("t5_idle", 64'(busy), 64'd0);

      $display("[TB] four-requester instance wrap");
      req2 = 4'b1000;
      applyStimulus();
      checkOutput("t6_sel3", 64'(select2), 64'd3);
      applyStimulus();
      checkOutput("t6_gnt3", 64'(gnt2), 64'(4'b1000));
      checkOutput("t6_data3", outData2, d2[3]);
      req2 = 4'b1001;
      applyStimulus();
      checkOutput("t6_wrap_sel", 64'(select2), 64'd0);
      checkOutput("t6_gap", 64'(outValid2), 64'd0);
      applyStimulus();
      checkOutput("t6_gnt0", 64'(gnt2), 64'(4'b0001));
      checkOutput("t6_data0", outData2, d2[0]);
      req2 = '0;
      applyStimulus();
      applyStimulus();
      checkOutput("t6_idle", 64'(busy2), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
